regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a per-register busy scoreboard for the NPC in-order core. Generalises the single-write, two-read register file: it adds configurable width, depth and read-port count, same-cycle write-to-read bypass, asynchronous reset of the whole array, and busy-bit tracking so decode can stall on RAW and WAW hazards. It sits between decode/issue, which reads sources and claims a destination, and writeback, which writes results and releases the destination.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; AW = clog2(NREG)
- NRD, 2, number of combinational read ports
- SP_IDX, 2, index of the register with a non-zero reset value
- SP_RST, 32'd128, reset value of register SP_IDX

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- raddr  input  NRD*AW  read addresses; port i is raddr[i*AW +: AW]
- rdata  output  NRD*XLEN  read data; port i is rdata[i*XLEN +: XLEN]
- rhazard  output  NRD  port i source is busy and not bypassed this cycle
- we  input  1  writeback valid
- waddr  input  AW  writeback destination
- wdata  input  XLEN  writeback data
- issue_valid  input  1  decode requests to issue an instruction
- issue_rd  input  AW  destination claimed by the issuing instruction (0 = none)
- issue_ready  output  1  issue accepted this cycle if issue_valid is high
- busy_cnt  output  AW+1  number of registers currently busy
- wb_err  output  1  sticky flag: writeback to a non-busy, non-zero register

## Operation
- Reset (rst low, asynchronous): all registers 0 except regs[SP_IDX] = SP_RST; all busy bits 0; busy_cnt 0; wb_err 0. rdata reflects the reset contents immediately.
- Register x0: reads always return 0. Writes are ignored. x0 is never busy, and issue_rd = 0 claims nothing.
- Read port i, combinational:
  - raddr_i = 0 -> 0.
  - Otherwise, if we and waddr = raddr_i -> wdata (bypass).
  - Otherwise -> regs[raddr_i].
- rhazard[i] = busy[raddr_i] and not (we and waddr = raddr_i). It is always 0 for raddr_i = 0.
- WAW check: waw = issue_rd != 0 and busy[issue_rd] and not (we and waddr = issue_rd).
- issue_ready = no rhazard bit set and not waw. It is combinational and does not depend on issue_valid.
- fire = issue_valid and issue_ready. Decode must hold raddr and issue_rd stable while issue_valid is high.
- Write (we and waddr != 0): regs[waddr] <= wdata and busy[waddr] <= 0. If busy[waddr] was 0, wb_err <= 1; it stays 1 until reset.
- Claim (fire and issue_rd != 0): busy[issue_rd] <= 1.
- Simultaneous write-release and claim of the same register: the data is written and busy ends at 1 (the new producer wins). busy_cnt is unchanged.
- busy_cnt update each edge: +1 for a claim of a non-busy register, -1 for a release of a busy register. A claim and a release of different registers leave it unchanged. It never wraps; the maximum is NREG-1.

## Timing
- Read latency: 0 cycles (combinational, including bypass).
- Write: visible via bypass in the same cycle, and via the array from the next cycle.
- Busy set or clear, busy_cnt and wb_err: take effect at the edge after the triggering cycle.
- An instruction claiming rd in cycle N sees rhazard on rd from cycle N+1.
- An instruction reading rd in the writeback cycle gets the bypassed value with rhazard = 0.
- Reset asserted mid-operation overrides any pending write or claim in that cycle.
- Deassertion takes effect at the first edge after rst rises.

## Test plan
- Reset: assert rst low mid-run -> every rdata = 0 except raddr = 2, which reads 128; busy_cnt = 0; wb_err = 0; issue_ready = 1.
- RAW stall and bypass:
  - Issue issue_rd = 5 in cycle 0 -> cycle 1 with raddr0 = 5 gives rhazard[0] = 1, issue_ready = 0, busy_cnt = 1.
  - Cycle 3 with we = 1, waddr = 5, wdata = 0xDEADBEEF -> rdata0 = 0xDEADBEEF, rhazard[0] = 0, issue_ready = 1 in that same cycle.
  - Cycle 4 -> busy_cnt = 0.
- WAW: x7 busy, then issue_valid with issue_rd = 7 and no writeback -> issue_ready = 0 and busy_cnt stays 1. Adding we with waddr = 7 in the same cycle -> issue_ready = 1, busy[7] stays 1, busy_cnt stays 1.
- x0: write 0xFFFFFFFF to x0, then issue_rd = 0 -> rdata for x0 = 0, busy_cnt unchanged, rhazard never set for x0.
- Spurious writeback: write x9 while it is not busy -> data is written, wb_err = 1 on the next cycle, and wb_err stays 1 until rst goes low.
- Count range: claim x1..x31 one per cycle, with no reads of pending registers -> busy_cnt reaches 31; releasing all of them returns it to 0 without wrap.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register busy scoreboard.
// Reads are combinational with writeback bypass; issue_ready stalls decode on RAW/WAW hazards.
module regfile_sb #(
  parameter int unsigned     XLEN   = 32,
  parameter int unsigned     NREG   = 32,
  parameter int unsigned     NRD    = 2,
  parameter int unsigned     SP_IDX = 2,
  parameter logic [XLEN-1:0] SP_RST = XLEN'(128),
  localparam int unsigned    AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rhazard,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  output logic [AW:0]         busy_cnt,
  output logic                wb_err
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_nxt;
  logic [AW-1:0]   ra;
  logic            byp;
  logic            waw;
  logic            fire;
  logic            wr;
  logic            claim;

  // Read ports: x0 reads zero, a same-cycle writeback bypasses the array and clears the hazard.
  always_comb begin
    rdata   = '0;
    rhazard = '0;
    ra      = '0;
    byp     = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra  = raddr[i*AW +: AW];
      byp = we && (waddr == ra);
      if (ra != '0) begin
        rdata[i*XLEN +: XLEN] = byp ? wdata : regs[ra];
        rhazard[i]            = busy[ra] && !byp;
      end
    end
  end

  always_comb begin
    waw         = (issue_rd != '0) && busy[issue_rd] && !(we && (waddr == issue_rd));
    issue_ready = (rhazard == '0) && !waw;
    fire        = issue_valid && issue_ready;
    wr          = we && (waddr != '0);
    claim       = fire && (issue_rd != '0);
  end

  // Release before claim so a same-register claim leaves the new producer marked busy.
  always_comb begin
    busy_nxt = busy;
    if (wr) busy_nxt[waddr] = 1'b0;
    if (claim) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (wr && !busy[waddr]) wb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
    end else if (wr) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: expected values queued at stimulus time, compared against observed outputs.
module tb_regfile_sb;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [2*AW-1:0]   raddr;
  logic [2*XLEN-1:0] rdata;
  logic [1:0]        rhazard;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              issue_ready;
  logic [AW:0]       busy_cnt;
  logic              wb_err;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rhazard(rhazard),
    .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_ready(issue_ready), .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    issue_valid = 1'b0; issue_rd = '0; raddr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic expect_v(input string n, input logic [31:0] v);
    exp_q.push_back('{n, v});
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic test_raw_bypass();
    exp_t e;
    idle(); issue_valid = 1'b1; issue_rd = 5'd5; #1;
    expect_v("raw_c0_ready", 1); observe(32'(issue_ready));
    tick();
    idle(); set_ra(5'd5, 5'd0); #1;
    expect_v("raw_c1_hazard", 1); observe(32'(rhazard[0]));
    expect_v("raw_c1_ready", 0);  observe(32'(issue_ready));
    expect_v("raw_c1_cnt", 1);    observe(32'(busy_cnt));
    tick(); tick();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_ra(5'd5, 5'd5); #1;
    expect_v("raw_c3_rdata0", 32'hDEADBEEF); observe(rdata[31:0]);
    expect_v("raw_c3_rdata1", 32'hDEADBEEF); observe(rdata[63:32]);
    expect_v("raw_c3_hazard", 0);            observe(32'(rhazard));
    expect_v("raw_c3_ready", 1);             observe(32'(issue_ready));
    tick();
    idle(); set_ra(5'd5, 5'd0); #1;
    expect_v("raw_c4_cnt", 0);              observe(32'(busy_cnt));
    expect_v("raw_c4_array", 32'hDEADBEEF); observe(rdata[31:0]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0] !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, obs_q.size() ? obs_q[0] : 32'hx, e.val);
      end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  task automatic test_waw();
    exp_t e;
    idle(); issue_valid = 1'b1; issue_rd = 5'd7; tick();
    #1;
    expect_v("waw_ready_blocked", 0); observe(32'(issue_ready));
    tick();
    expect_v("waw_cnt_held", 1); observe(32'(busy_cnt));
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0077; #1;
    expect_v("waw_ready_wb", 1); observe(32'(issue_ready));
    tick();
    idle(); set_ra(5'd7, 5'd0); #1;
    expect_v("waw_cnt_after", 1);   observe(32'(busy_cnt));
    expect_v("waw_still_busy", 1);  observe(32'(rhazard[0]));
    expect_v("waw_data", 32'h77);   observe(rdata[31:0]);
    we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0078; tick();
    idle(); #1;
    expect_v("waw_released", 0); observe(32'(busy_cnt));
    expect_v("waw_no_err", 0);   observe(32'(wb_err));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0] !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, obs_q.size() ? obs_q[0] : 32'hx, e.val);
      end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  task automatic test_x0();
    exp_t e;
    idle(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; #1;
    expect_v("x0_no_bypass", 0); observe(rdata[31:0]);
    expect_v("x0_no_hazard", 0); observe(32'(rhazard));
    tick();
    idle(); issue_valid = 1'b1; issue_rd = 5'd0; #1;
    expect_v("x0_issue_ready", 1); observe(32'(issue_ready));
    tick();
    idle(); #1;
    expect_v("x0_read", 0);       observe(rdata[31:0]);
    expect_v("x0_cnt", 0);        observe(32'(busy_cnt));
    expect_v("x0_hazard", 0);     observe(32'(rhazard));
    expect_v("x0_no_err", 0);     observe(32'(wb_err));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0] !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, obs_q.size() ? obs_q[0] : 32'hx, e.val);
      end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  task automatic test_count();
    exp_t e;
    for (int r = 1; r < 32; r++) begin
      idle(); issue_valid = 1'b1; issue_rd = AW'(r); #1;
      expect_v($sformatf("cnt_claim_ready_%0d", r), 1); observe(32'(issue_ready));
      tick();
    end
    idle(); set_ra(5'd0, 5'd17); #1;
    expect_v("cnt_full", 31);      observe(32'(busy_cnt));
    expect_v("cnt_hazard17", 1);   observe(32'(rhazard[1]));
    for (int r = 1; r < 32; r++) begin
      idle(); we = 1'b1; waddr = AW'(r); wdata = 32'(r * 3);
      tick();
      if (r == 16) begin
        expect_v("cnt_half", 15); observe(32'(busy_cnt));
      end
    end
    idle(); set_ra(5'd31, 5'd2); #1;
    expect_v("cnt_empty", 0);   observe(32'(busy_cnt));
    expect_v("cnt_x31", 93);    observe(rdata[31:0]);
    expect_v("cnt_x2", 6);      observe(rdata[63:32]);
    expect_v("cnt_no_err", 0);  observe(32'(wb_err));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0] !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, obs_q.size() ? obs_q[0] : 32'hx, e.val);
      end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  task automatic test_wb_err();
    exp_t e;
    idle(); we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0099; #1;
    expect_v("err_not_yet", 0); observe(32'(wb_err));
    tick();
    idle(); set_ra(5'd9, 5'd0); #1;
    expect_v("err_set", 1);     observe(32'(wb_err));
    expect_v("err_data", 32'h99); observe(rdata[31:0]);
    tick(); tick(); tick();
    expect_v("err_sticky", 1);  observe(32'(wb_err));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0] !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, obs_q.size() ? obs_q[0] : 32'hx, e.val);
      end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  task automatic test_reset();
    exp_t e;
    idle(); issue_valid = 1'b1; issue_rd = 5'd4; tick();
    idle(); #1;
    expect_v("rst_pre_cnt", 1); observe(32'(busy_cnt));
    #2 rst = 1'b0;
    #1;
    expect_v("rst_cnt", 0);     observe(32'(busy_cnt));
    expect_v("rst_err", 0);     observe(32'(wb_err));
    expect_v("rst_ready", 1);   observe(32'(issue_ready));
    for (int a = 0; a < 32; a++) begin
      set_ra(AW'(a), AW'(31 - a)); #1;
      expect_v($sformatf("rst_rd0_x%0d", a), (a == 2) ? 32'd128 : 32'd0);
      observe(rdata[31:0]);
      expect_v($sformatf("rst_rd1_x%0d", 31 - a), (31 - a == 2) ? 32'd128 : 32'd0);
      observe(rdata[63:32]);
    end
    tick();
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_AAAA; issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    idle(); set_ra(5'd3, 5'd6); #1;
    expect_v("rst_override_wr", 0);    observe(rdata[31:0]);
    expect_v("rst_override_claim", 0); observe(32'(rhazard));
    #1 rst = 1'b1;
    tick(); #1;
    expect_v("rst_release_cnt", 0);  observe(32'(busy_cnt));
    expect_v("rst_release_err", 0);  observe(32'(wb_err));
    expect_v("rst_release_x3", 0);   observe(rdata[31:0]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0] !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, obs_q.size() ? obs_q[0] : 32'hx, e.val);
      end
      if (obs_q.size() > 0) void'(obs_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b1;
    tick();
    test_raw_bypass();
    test_waw();
    test_x0();
    test_count();
    test_wb_err();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
